// File: rtl/ring_meas_pkg.sv
// Shared types and default sizing for the ring oscillator measurement controller.
package ring_meas_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned WIN_W_DEF  = 12;
  localparam int unsigned SETTLE_DEF = 4;
  localparam int unsigned DRAIN_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_STOP    = 3'd3,
    ST_REPORT  = 3'd4
  } state_e;

endpackage

// File: rtl/ring_meas_ctrl_if.sv
// Control/result/ring-tap bundle of ring_meas_ctrl; slave is the controller side.
// RING_MEAS_CONT_EN adds the cont request line.
interface ring_meas_ctrl_if
  import ring_meas_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF
);
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] window;
  logic             ring_q;
  logic             ring_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             ovf;
`ifdef RING_MEAS_CONT_EN
  logic             cont;
`endif

  modport master (
`ifdef RING_MEAS_CONT_EN
    output cont,
`endif
    output start, abort, window, ring_q,
    input  ring_en, busy, done, count, ovf
  );

  modport slave (
`ifdef RING_MEAS_CONT_EN
    input  cont,
`endif
    input  start, abort, window, ring_q,
    output ring_en, busy, done, count, ovf
  );

endinterface

// File: rtl/ring_edge_sync.sv
// Two-flop synchronizer for an asynchronous tap plus a rising-edge pulse on the synchronized value.
module ring_edge_sync (
  input  logic clk,
  input  logic rn,
  input  logic tap,
  output logic rise_c
);
  // [0] metastability stage, [1] synchronized value, [2] its delayed copy
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], tap};
  end

  assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ring_meas_ctrl.sv
// Ring oscillator sequencer and frequency meter: settle, count tap edges over a window, drain, report.
// Define RING_MEAS_CONT_EN for back-to-back measurements while bus.cont is high.
module ring_meas_ctrl
  import ring_meas_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WIN_W  = WIN_W_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF,
  parameter int unsigned DRAIN  = DRAIN_DEF
) (
  input logic             clk,
  input logic             rn,
  ring_meas_ctrl_if.slave bus
);
  localparam int unsigned      TMR_W     = WIN_W;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(DRAIN - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             abrt_q, abrt_d;
  logic             ring_en_q, busy_q, done_q, ovf_q;
  logic [CNT_W-1:0] count_q;
  logic             rise_c;
  logic             cont_c;

  ring_edge_sync u_tap_sync (
    .clk    (clk),
    .rn     (rn),
    .tap    (bus.ring_q),
    .rise_c (rise_c)
  );

`ifdef RING_MEAS_CONT_EN
  assign cont_c = bus.cont;
`else
  assign cont_c = 1'b0;
`endif

  // State register plus outputs registered from the next state
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      abrt_q    <= 1'b0;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      abrt_q    <= abrt_d;
      ring_en_q <= (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_REPORT);
      if (state_d == ST_REPORT) begin
        count_q <= cnt_q;
        ovf_q   <= sat_q;
      end
    end
  end

  // Next-state, phase timer and saturating edge counter
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    abrt_d  = abrt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          win_d   = bus.window;
          tmr_d   = SETTLE_LD;
          cnt_d   = '0;
          sat_d   = 1'b0;
          abrt_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_d = ST_STOP;
          abrt_d  = 1'b1;
          tmr_d   = DRAIN_LD;
        end else if (tmr_q == '0) begin
          if (win_q == '0) begin
            state_d = ST_STOP;
            tmr_d   = DRAIN_LD;
          end else begin
            state_d = ST_MEASURE;
            tmr_d   = win_q - TMR_W'(1);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        if (bus.abort) begin
          state_d = ST_STOP;
          abrt_d  = 1'b1;
          tmr_d   = DRAIN_LD;
        end else begin
          if (rise_c) begin
            if (&cnt_q) sat_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
          end
          if (tmr_q == '0) begin
            state_d = ST_STOP;
            tmr_d   = DRAIN_LD;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tmr_q == '0) state_d = abrt_q ? ST_IDLE : ST_REPORT;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_REPORT: begin
        // Continuous mode re-arms with the window latched at the original start
        if (cont_c) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_LD;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ring_en = ring_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.count   = count_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_ring_meas_ctrl.sv
// Bench for ring_meas_ctrl: two instances (16-bit and 4-bit counters) share stimulus and are
// checked every cycle against a schedule model; directed literals pin the model.
`timescale 1ns/1ps
module tb_ring_meas_ctrl;
  localparam int unsigned WIN_W = 12;
  localparam int          MAXC  = 4096;

  logic clk;
  logic rn;

  ring_meas_ctrl_if #(.CNT_W(16), .WIN_W(WIN_W)) ifc_a ();
  ring_meas_ctrl_if #(.CNT_W(4),  .WIN_W(WIN_W)) ifc_b ();

  assign ifc_b.start  = ifc_a.start;
  assign ifc_b.abort  = ifc_a.abort;
  assign ifc_b.window = ifc_a.window;
  assign ifc_b.ring_q = ifc_a.ring_q;
`ifdef RING_MEAS_CONT_EN
  assign ifc_b.cont   = ifc_a.cont;
`endif

  ring_meas_ctrl #(.CNT_W(16), .WIN_W(WIN_W), .SETTLE(4), .DRAIN(2)) dut_a (
    .clk (clk), .rn (rn), .bus (ifc_a));
  ring_meas_ctrl #(.CNT_W(4),  .WIN_W(WIN_W), .SETTLE(4), .DRAIN(2)) dut_b (
    .clk (clk), .rn (rn), .bus (ifc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int per   = 0;
  int ph    = 0;
  int en_hi = 0;
  bit q_at [MAXC];

  // schedule model of the current/last measurement
  bit m_run  = 1'b0;
  bit m_abrt = 1'b0;
  int m_n0 = 0, m_w = 0, m_en_last = 0, m_busy_last = 0, m_done_cyc = 0;
  int m_cnt_a = 0, m_cnt_b = 0;
  bit m_ovf_a = 1'b0, m_ovf_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // rising edges of the sampled tap seen while the window is open (two-flop latency)
  function automatic int edges_in_window(input int n0, input int w);
    int r = 0;
    for (int c = n0 + 4; c <= n0 + 3 + w; c++)
      if (c >= 2 && c < MAXC && q_at[c-1] && !q_at[c-2]) r++;
    return r;
  endfunction

  task automatic launch(input int n0, input int w);
    m_run = 1'b1; m_abrt = 1'b0; m_n0 = n0; m_w = w;
    m_en_last = n0 + 3 + w; m_busy_last = n0 + 6 + w; m_done_cyc = n0 + 6 + w;
  endtask

  // model update at each active edge
  initial forever begin
    bit cont_v;
    int r;
    @(posedge clk or negedge rn);
    if (!rn) begin
      m_run = 1'b0; m_abrt = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    end else begin
      cyc++;
      if (cyc < MAXC) q_at[cyc] = ifc_a.ring_q;
`ifdef RING_MEAS_CONT_EN
      cont_v = ifc_a.cont;
`else
      cont_v = 1'b0;
`endif
      if (m_run && !m_abrt && (cyc - 1 == m_done_cyc) && cont_v)
        launch(cyc, m_w);
      else if ((!m_run || (cyc - 1 > m_busy_last)) && ifc_a.start)
        launch(cyc, int'(ifc_a.window));
      else if (m_run && !m_abrt && ifc_a.abort && (cyc - 1 >= m_n0) && (cyc - 1 <= m_en_last)) begin
        m_abrt = 1'b1; m_en_last = cyc - 1; m_busy_last = cyc + 1;
      end
      if (m_run && !m_abrt && cyc == m_done_cyc) begin
        r = edges_in_window(m_n0, m_w);
        m_cnt_a = (r > 65535) ? 65535 : r; m_ovf_a = (r > 65535);
        m_cnt_b = (r > 15) ? 15 : r;       m_ovf_b = (r > 15);
      end
    end
  end

  // ring tap stimulus, changed away from the sampling edge
  initial begin
    ifc_a.ring_q = 1'b0;
    forever begin
      @(negedge clk);
      if (per > 0) begin
        ifc_a.ring_q = ((ph % per) < (per / 2));
        ph++;
      end else begin
        ifc_a.ring_q = 1'b0;
      end
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    bit e_en, e_busy, e_done;
    @(negedge clk);
    e_en   = m_run && (cyc >= m_n0) && (cyc <= m_en_last);
    e_busy = m_run && (cyc >= m_n0) && (cyc <= m_busy_last);
    e_done = m_run && !m_abrt && (cyc == m_done_cyc);
    if (ifc_a.ring_en === 1'b1) en_hi++;
    check("a_ring_en", 32'(ifc_a.ring_en), 32'(e_en));
    check("a_busy",    32'(ifc_a.busy),    32'(e_busy));
    check("a_done",    32'(ifc_a.done),    32'(e_done));
    check("a_count",   32'(ifc_a.count),   32'(m_cnt_a));
    check("a_ovf",     32'(ifc_a.ovf),     32'(m_ovf_a));
    check("b_ring_en", 32'(ifc_b.ring_en), 32'(e_en));
    check("b_busy",    32'(ifc_b.busy),    32'(e_busy));
    check("b_done",    32'(ifc_b.done),    32'(e_done));
    check("b_count",   32'(ifc_b.count),   32'(m_cnt_b));
    check("b_ovf",     32'(ifc_b.ovf),     32'(m_ovf_b));
  end

  task automatic pulse_start(input int w, input bit with_abort, output int n0);
    @(negedge clk);
    ifc_a.start  = 1'b1;
    ifc_a.window = WIN_W'(w);
    ifc_a.abort  = with_abort;
    @(negedge clk);
    n0 = cyc;
    ifc_a.start = 1'b0;
    ifc_a.abort = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    bit seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ifc_a.done === 1'b1) begin seen = 1'b1; dcyc = cyc; end
    end
    if (!seen) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 500 && cyc < target; i++) @(negedge clk);
    if (cyc < target) check("wait_cyc_timeout", 32'(cyc), 32'(target));
  endtask

  task automatic count_dones(input int ncyc, output int nd);
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ifc_a.done === 1'b1) nd++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, d, d2, e0, nd;
    rn = 1'b0;
    ifc_a.start = 1'b0; ifc_a.abort = 1'b0; ifc_a.window = '0;
`ifdef RING_MEAS_CONT_EN
    ifc_a.cont = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ring_en", 32'(ifc_a.ring_en), 32'(0));
    check("rst_busy",    32'(ifc_a.busy),    32'(0));
    check("rst_done",    32'(ifc_a.done),    32'(0));
    check("rst_count",   32'(ifc_a.count),   32'(0));
    check("rst_ovf",     32'(ifc_b.ovf),     32'(0));
    rn = 1'b1;
    repeat (2) @(negedge clk);

    // window 100, tap period 8
    per = 8;
    e0 = en_hi;
    pulse_start(100, 1'b0, n0);
    wait_done(200, d);
    check("lat_w100", 32'(d - (n0 - 1)), 32'(107));
    check("en_cycles_w100", 32'(en_hi - e0), 32'(104));
    check("count_w100_12or13", 32'((ifc_a.count == 16'd12) || (ifc_a.count == 16'd13)), 32'(1));
    check("ovf_w100", 32'(ifc_a.ovf), 32'(0));

    // zero window: edges during settle are not counted
    per = 4;
    pulse_start(0, 1'b0, n0);
    wait_done(40, d);
    check("lat_w0", 32'(d - (n0 - 1)), 32'(7));
    check("count_w0", 32'(ifc_a.count), 32'(0));

    // 50 edges: 16-bit exact, 4-bit saturates
    pulse_start(200, 1'b0, n0);
    wait_done(300, d);
    check("count_w200_a", 32'(ifc_a.count), 32'(50));
    check("count_w200_b", 32'(ifc_b.count), 32'(15));
    check("ovf_w200_b",   32'(ifc_b.ovf),   32'(1));

    // abort in the 10th measure cycle
    per = 8;
    pulse_start(100, 1'b0, n0);
    wait_cyc(n0 + 13);
    ifc_a.abort = 1'b1;
    @(negedge clk);
    ifc_a.abort = 1'b0;
    check("abort_en_low", 32'(ifc_a.ring_en), 32'(0));
    check("abort_busy_stop", 32'(ifc_a.busy), 32'(1));
    repeat (2) @(negedge clk);
    check("abort_busy_idle", 32'(ifc_a.busy), 32'(0));
    count_dones(120, nd);
    check("abort_no_done", 32'(nd), 32'(0));
    check("abort_count_held", 32'(ifc_a.count), 32'(50));
    check("abort_ovf_held_b", 32'(ifc_b.ovf), 32'(1));

    // extra start while busy is ignored
    per = 6;
    pulse_start(30, 1'b0, n0);
    wait_cyc(n0 + 10);
    pulse_start(50, 1'b0, n1);
    count_dones(80, nd);
    check("busy_start_one_done", 32'(nd), 32'(1));

    // start and abort together from idle: start wins
    pulse_start(20, 1'b1, n0);
    wait_done(60, d);
    check("start_abort_lat", 32'(d - (n0 - 1)), 32'(27));

    // asynchronous reset in the middle of a window
    per = 8;
    pulse_start(100, 1'b0, n0);
    wait_cyc(n0 + 25);
    #2 rn = 1'b0;
    #1;
    check("rn_en_low",  32'(ifc_a.ring_en), 32'(0));
    check("rn_count_a", 32'(ifc_a.count),   32'(0));
    check("rn_busy",    32'(ifc_a.busy),    32'(0));
    check("rn_count_b", 32'(ifc_b.count),   32'(0));
    @(negedge clk);
    rn = 1'b1;
    per = 6;
    pulse_start(16, 1'b0, n0);
    wait_done(60, d);
    check("post_rn_lat", 32'(d - (n0 - 1)), 32'(23));

`ifdef RING_MEAS_CONT_EN
    ifc_a.cont = 1'b1;
    per = 8;
    pulse_start(20, 1'b0, n0);
    wait_done(60, d);
    wait_done(60, d2);
    check("cont_period_1", 32'(d2 - d), 32'(27));
    wait_done(60, d);
    check("cont_period_2", 32'(d - d2), 32'(27));
    ifc_a.cont = 1'b0;
    @(negedge clk);
    check("cont_stop_busy", 32'(ifc_a.busy), 32'(0));
    count_dones(60, nd);
    check("cont_stop_no_done", 32'(nd), 32'(0));
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
